lab8_fetch_unit: RTL and testbench
==================================

// Module: lab8_fetch_unit
// PURPOSE
//   Instruction-fetch front end of the lab8 CPU. Owns PC and IR, sequences the
//   IF1/IF2/UPDATE_PC states, and hands each fetched instruction to the execute
//   controller over a valid/done handshake. Arbitrates the single RAM port
//   between fetch and the execute stage. Drives the sticky halt flag that the
//   top level routes to LEDR[8].
// PARAMETERS
//   ADDR_W    9       RAM word-address width; PC width
//   DATA_W    16      instruction/data word width
//   RESET_PC  9'h000  PC value loaded on reset
// PORTS
//   clk           in   1       system clock; all state changes on posedge
//   reset_n       in   1       asynchronous active-low reset
//   mem_addr      out  ADDR_W  RAM address
//   mem_cmd       out  2       00 NONE, 01 READ, 10 WRITE
//   mem_rdata     in   DATA_W  RAM read data, valid 1 cycle after READ is presented
//   exec_addr     in   ADDR_W  execute-stage address; passed through while in DISPATCH
//   exec_cmd      in   2       execute-stage command; passed through while in DISPATCH
//   instr_valid   out  1       IR holds an instruction awaiting execution
//   ir            out  DATA_W  instruction register
//   exec_done     in   1       execute stage finished the current instruction
//   pc_load       in   1       with exec_done: load PC from pc_target (branch)
//   pc_target     in   ADDR_W  branch destination
//   pc            out  ADDR_W  program counter
//   halted        out  1       sticky; HALT opcode fetched
//   instr_count   out  16      instructions dispatched, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (async, reset_n=0): state=RST, pc=RESET_PC, ir=0, halted=0,
//     instr_count=0, instr_valid=0, mem_cmd=NONE, mem_addr=0.
//   State encoding (4 bits, fixed; benches probe it):
//     RST=0000 IF1=0001 IF2=0010 UPD=0011 DISPATCH=0100 HALT=0101.
//   RST -> IF1 unconditionally on the first clock after reset release.
//   IF1: mem_addr=pc, mem_cmd=READ -> IF2.
//   IF2: mem_addr=pc, mem_cmd=READ; ir<=mem_rdata at the clock edge -> UPD.
//   UPD: mem_cmd=NONE; pc<=pc+1, modulo 2^ADDR_W (1FF -> 000).
//     If ir[15:13]==3'b111: -> HALT. Otherwise -> DISPATCH;
//     instr_count increments on this edge (saturating).
//   DISPATCH: instr_valid=1; mem_addr/mem_cmd = exec_addr/exec_cmd (pure mux).
//     exec_done=1 (sampled every DISPATCH cycle, including the first) -> IF1;
//     on the same edge pc<=pc_target if pc_load=1, else pc unchanged.
//   HALT: halted=1 (registered, asserted from the first HALT cycle); mem_cmd=NONE;
//     instr_valid=0; pc frozen at halt address+1. Only reset exits HALT.
//   exec_done and pc_load are ignored outside DISPATCH; pc_load without
//     exec_done is ignored.
//   Fetch latency: 3 clocks IF1->DISPATCH; minimum 4 clocks per instruction.
//   Reset asserted in any state aborts immediately; no partial IR/PC update.
//   The only multi-driver case (simultaneous fetch and exec access) is
//     impossible by construction: exec owns the bus only in DISPATCH.
// TESTING
//   T1 reset: hold reset_n=0 2 cycles, release -> next edge state=IF1,
//      mem_addr=000, mem_cmd=01, pc=000, halted=0, instr_count=0.
//   T2 fetch: mem[000]=16'hD105 -> ir=D105 after IF2, pc=001 after UPD,
//      instr_valid=1, instr_count=1; exec_done held 0 for 5 cycles -> stays DISPATCH.
//   T3 branch: in DISPATCH, exec_done=1, pc_load=1, pc_target=019 -> next IF1
//      mem_addr=019; repeat with pc_load=0 -> mem_addr=pc+1 path (002).
//   T4 bus pass-through: DISPATCH with exec_cmd=10, exec_addr=019 -> mem_cmd=10,
//      mem_addr=019 the same cycle; in IF1, exec_cmd changes have no effect.
//   T5 halt: mem[002]=16'hE000 -> halted=1, state=HALT, pc=003, no further
//      READ for 20 cycles; exec_done pulses ignored.
//   T6 wrap/reset: pc=1FF fetch -> pc=000; assert reset_n=0 mid-IF2 -> state=RST,
//      pc=000, ir=0000 immediately (asynchronous).

Source files
------------

// File: rtl/lab8_fetch_if.sv
// Bus bundle between the lab8 fetch unit, the RAM port and the execute controller.
// Handshake: the fetch unit holds instr_valid=1 with a stable ir until the execute stage
// raises exec_done. The instruction retires on the first rising clk edge where both are 1.
// pc_load/pc_target are only meaningful on that same edge. exec_addr/exec_cmd reach the
// RAM only while instr_valid=1.
interface lab8_fetch_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_cmd;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] exec_addr;
    logic [1:0]        exec_cmd;
    logic              instr_valid;
    logic [DATA_W-1:0] ir;
    logic              exec_done;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;

    modport master (
        output mem_addr, mem_cmd, instr_valid, ir,
        input  mem_rdata, exec_addr, exec_cmd, exec_done, pc_load, pc_target
    );

    modport slave (
        input  mem_addr, mem_cmd, instr_valid, ir,
        output mem_rdata, exec_addr, exec_cmd, exec_done, pc_load, pc_target
    );
endinterface

// File: rtl/lab8_fetch_unit.sv
// Instruction-fetch front end of the lab8 CPU: owns PC/IR, sequences IF1/IF2/UPD,
// dispatches to the execute stage and shares the single RAM port with it.
module lab8_fetch_unit #(
    parameter int              ADDR_W   = 9,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    lab8_fetch_if.master      bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [15:0]       instr_count,
    output logic [3:0]        state_dbg
);

    typedef enum logic [3:0] {
        ST_RST      = 4'b0000,
        ST_IF1      = 4'b0001,
        ST_IF2      = 4'b0010,
        ST_UPD      = 4'b0011,
        ST_DISPATCH = 4'b0100,
        ST_HALT     = 4'b0101
    } state_t;

    localparam logic [1:0]  CMD_NONE  = 2'b00;
    localparam logic [1:0]  CMD_READ  = 2'b01;
    localparam logic [2:0]  OP_HALT   = 3'b111;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic                halted_q, halted_d;
    logic [15:0]         count_q, count_d;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [1:0]          mem_cmd_c;
    logic                instr_valid_c;
    logic                ir_is_halt;

    assign ir_is_halt = (ir_q[DATA_W-1 -: 3] == OP_HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RST;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        halted_d      = halted_q;
        count_d       = count_q;
        mem_addr_c    = '0;
        mem_cmd_c     = CMD_NONE;
        instr_valid_c = 1'b0;

        case (state_q)
            ST_RST: begin
                state_d = ST_IF1;
            end
            ST_IF1: begin
                mem_addr_c = pc_q;
                mem_cmd_c  = CMD_READ;
                state_d    = ST_IF2;
            end
            ST_IF2: begin
                // RAM answers one cycle after READ, so the word is present now.
                mem_addr_c = pc_q;
                mem_cmd_c  = CMD_READ;
                ir_d       = bus.mem_rdata;
                state_d    = ST_UPD;
            end
            ST_UPD: begin
                mem_addr_c = pc_q;
                pc_d       = pc_q + ADDR_W'(1);
                if (ir_is_halt) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_DISPATCH;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            ST_DISPATCH: begin
                // Execute stage owns the RAM port for the whole dispatch window.
                instr_valid_c = 1'b1;
                mem_addr_c    = bus.exec_addr;
                mem_cmd_c     = bus.exec_cmd;
                if (bus.exec_done) begin
                    state_d = ST_IF1;
                    if (bus.pc_load) begin
                        pc_d = bus.pc_target;
                    end
                end
            end
            ST_HALT: begin
                mem_addr_c = pc_q;
                halted_d   = 1'b1;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_cmd     = mem_cmd_c;
    assign bus.instr_valid = instr_valid_c;
    assign bus.ir          = ir_q;
    assign pc              = pc_q;
    assign halted          = halted_q;
    assign instr_count     = count_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_lab8_fetch_unit.sv
// Bench for lab8_fetch_unit: directed reset/fetch/branch/halt/wrap scenarios, then random
// dispatch traffic checked by a scoreboard fed from an architectural program model.
module tb_lab8_fetch_unit;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int EW = DW + AW + 16;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] pc;
  logic          halted;
  logic [15:0]   instr_count;
  logic [3:0]    state_dbg;

  lab8_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lab8_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(9'h000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .pc          (pc),
    .halted      (halted),
    .instr_count (instr_count),
    .state_dbg   (state_dbg)
  );

  int            checks;
  int            errors;
  int            read_total;
  logic [DW-1:0] mem [0:511];
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] model_pc;
  logic [15:0]   model_cnt;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // RAM model: registered read, one cycle of latency
  initial read_total = 0;
  always @(posedge clk) begin
    if (bus.mem_cmd == 2'b01) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      read_total    <= read_total + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_instr();
    logic [DW-1:0] w;
    w = DW'($urandom);
    if (w[15:13] == 3'b111) w[13] = 1'b0;
    return w;
  endfunction

  // architectural model: fetching address a retires mem[a] unless it is a HALT
  task automatic model_fetch(input logic [AW-1:0] a);
    model_pc = a + 9'd1;
    if (mem[a][15:13] != 3'b111) begin
      if (model_cnt != 16'hFFFF) model_cnt++;
      exp_q.push_back({mem[a], model_pc, model_cnt});
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (state_dbg !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg !== s) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=%0h expected=%0h", name, state_dbg, s);
    end
  endtask

  // driver: retire the current instruction, optionally branching
  task automatic issue(input logic load, input logic [AW-1:0] tgt);
    bus.exec_done = 1'b1;
    bus.pc_load   = load;
    bus.pc_target = tgt;
    model_fetch(load ? tgt : model_pc);
    @(negedge clk);
    bus.exec_done = 1'b0;
    bus.pc_load   = 1'b0;
  endtask

  // monitor: every new dispatch is compared with the oldest expected instruction
  initial begin
    logic          prev;
    logic [EW-1:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && bus.instr_valid === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dispatch_unexpected actual ir=%0h pc=%0h expected none", bus.ir, pc);
        end else begin
          e = exp_q.pop_front();
          check("dispatch_ir", bus.ir, e[EW-1 -: DW]);
          check("dispatch_pc", pc, e[16 +: AW]);
          check("dispatch_count", instr_count, e[15:0]);
        end
      end
      prev = bus.instr_valid;
    end
  end

  initial begin
    logic          ld;
    logic [AW-1:0] tg;
    int            base;
    int            d;
    checks = 0;
    errors = 0;
    model_cnt = 0;
    model_pc = 0;
    reset_n = 1'b0;
    bus.exec_addr = '0;
    bus.exec_cmd = 2'b00;
    bus.exec_done = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_target = '0;
    for (int i = 0; i < 512; i++) mem[i] = rand_instr();
    mem[9'h000] = 16'hD105;
    mem[9'h002] = 16'hE000;
    mem[9'h019] = 16'h4321;
    mem[9'h1FF] = 16'h1234;

    // T1 reset
    repeat (2) @(negedge clk);
    check("rst_state", state_dbg, 4'h0);
    check("rst_pc", pc, 9'h000);
    check("rst_ir", bus.ir, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_count", instr_count, 16'h0000);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_cmd", bus.mem_cmd, 2'b00);
    check("rst_addr", bus.mem_addr, 9'h000);
    model_fetch(9'h000);
    reset_n = 1'b1;
    @(negedge clk);
    check("t1_state", state_dbg, 4'h1);
    check("t1_addr", bus.mem_addr, 9'h000);
    check("t1_cmd", bus.mem_cmd, 2'b01);
    check("t1_pc", pc, 9'h000);
    check("t1_halted", halted, 1'b0);
    check("t1_count", instr_count, 16'h0000);

    // T4 part: exec bus has no effect during IF1
    bus.exec_cmd = 2'b10;
    bus.exec_addr = 9'h055;
    #1;
    check("if1_cmd", bus.mem_cmd, 2'b01);
    check("if1_addr", bus.mem_addr, 9'h000);
    bus.exec_cmd = 2'b00;
    bus.exec_addr = '0;

    // T2 fetch
    wait_state(4'h3, 8, "t2_upd");
    check("t2_ir", bus.ir, 16'hD105);
    check("t2_upd_cmd", bus.mem_cmd, 2'b00);
    wait_state(4'h4, 4, "t2_disp");
    check("t2_pc", pc, 9'h001);
    check("t2_valid", bus.instr_valid, 1'b1);
    check("t2_count", instr_count, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold", state_dbg, 4'h4);
    end

    // T4 pass-through in DISPATCH
    bus.exec_cmd = 2'b10;
    bus.exec_addr = 9'h019;
    #1;
    check("t4_cmd", bus.mem_cmd, 2'b10);
    check("t4_addr", bus.mem_addr, 9'h019);
    @(negedge clk);
    bus.exec_cmd = 2'b00;
    bus.exec_addr = '0;

    // T3 branch / sequential
    issue(1'b1, 9'h019);
    check("t3_state", state_dbg, 4'h1);
    check("t3_addr", bus.mem_addr, 9'h019);
    wait_state(4'h4, 8, "t3_disp");
    check("t3_pc", pc, 9'h01A);
    issue(1'b1, 9'h001);
    check("t3_addr2", bus.mem_addr, 9'h001);
    wait_state(4'h4, 8, "t3_disp2");
    check("t3_pc2", pc, 9'h002);
    issue(1'b0, 9'h1AA);
    check("t3_seq_state", state_dbg, 4'h1);
    check("t3_seq_addr", bus.mem_addr, 9'h002);

    // T5 halt
    wait_state(4'h5, 8, "t5_halt");
    check("t5_halted", halted, 1'b1);
    check("t5_pc", pc, 9'h003);
    check("t5_valid", bus.instr_valid, 1'b0);
    check("t5_count", instr_count, 16'h0003);
    check("t5_cmd", bus.mem_cmd, 2'b00);
    base = read_total;
    for (int i = 0; i < 20; i++) begin
      bus.exec_done = i[0];
      bus.pc_load = 1'b1;
      bus.pc_target = 9'h040;
      @(negedge clk);
    end
    bus.exec_done = 1'b0;
    bus.pc_load = 1'b0;
    check("t5_reads", read_total - base, 0);
    check("t5_state_hold", state_dbg, 4'h5);
    check("t5_pc_hold", pc, 9'h003);
    check("t5_halted_hold", halted, 1'b1);
    check("t5_q_empty", exp_q.size(), 0);

    // T6 wrap and asynchronous reset
    reset_n = 1'b0;
    #1;
    check("t6_halt_clr", halted, 1'b0);
    check("t6_rst_state", state_dbg, 4'h0);
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    model_fetch(9'h000);
    reset_n = 1'b1;
    wait_state(4'h4, 8, "t6_disp");
    issue(1'b1, 9'h1FF);
    wait_state(4'h4, 8, "t6_disp2");
    check("t6_wrap_pc", pc, 9'h000);
    check("t6_wrap_ir", bus.ir, 16'h1234);
    issue(1'b0, 9'h000);
    @(negedge clk);
    check("t6_in_if2", state_dbg, 4'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_state", state_dbg, 4'h0);
    check("t6_async_pc", pc, 9'h000);
    check("t6_async_ir", bus.ir, 16'h0000);
    check("t6_async_cmd", bus.mem_cmd, 2'b00);
    check("t6_async_addr", bus.mem_addr, 9'h000);
    exp_q.delete();
    model_cnt = 0;

    // random traffic against the program model
    mem[9'h002] = rand_instr();
    @(negedge clk);
    model_fetch(9'h000);
    reset_n = 1'b1;
    for (int n = 0; n < 60; n++) begin
      wait_state(4'h4, 8, "rnd_disp");
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        bus.exec_cmd = 2'($urandom);
        bus.exec_addr = 9'($urandom);
        bus.pc_load = 1'($urandom);
        bus.pc_target = 9'($urandom);
        #1;
        check("rnd_pass_cmd", bus.mem_cmd, bus.exec_cmd);
        check("rnd_pass_addr", bus.mem_addr, bus.exec_addr);
        @(negedge clk);
      end
      bus.exec_cmd = 2'b00;
      bus.exec_addr = '0;
      ld = 1'($urandom_range(0, 1));
      tg = 9'($urandom);
      issue(ld, tg);
      for (int k = 0; k < 2; k++) begin
        bus.exec_done = 1'($urandom);
        bus.pc_load = 1'($urandom);
        bus.pc_target = 9'($urandom);
        @(negedge clk);
      end
      bus.exec_done = 1'b0;
      bus.pc_load = 1'b0;
    end
    wait_state(4'h4, 8, "rnd_last");
    @(negedge clk);
    check("rnd_q_empty", exp_q.size(), 0);
    check("rnd_count", instr_count, model_cnt);
    check("rnd_halted", halted, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
